// File: rtl/framebuffer_streamer_pkg.sv
// streamer_pkg: shared constants, output FSM state and data typedefs for framebuffer_streamer
package streamer_pkg;
   localparam int NB_DRIVERS  = 30;
   localparam int NB_CHANNELS = 48;
   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_BLANK, S_STREAM} state_t;
   typedef logic [NB_DRIVERS-1:0] word_t;
   typedef logic [$clog2(NB_CHANNELS)-1:0] entry_t;
endpackage

// File: rtl/framebuffer_streamer_bitplane_buffer.sv
// bitplane_buffer: two banks of 48 slice entries, one write port, transposing bit-plane read
//   clk_33                  clock
//   we/wbank/wentry/wdata   write port: entry wentry of bank wbank
//   rbank/rentry/rplane     read select; rword[d] = bit rplane of lane d of the entry
module bitplane_buffer
   import streamer_pkg::*;
#(
   parameter int  POKER_MODE = 9,
   localparam int PW         = POKER_MODE > 1 ? $clog2(POKER_MODE) : 1
) (
   input  logic                             clk_33,
   input  logic                             we,
   input  logic                             wbank,
   input  entry_t                           wentry,
   input  logic [NB_DRIVERS*POKER_MODE-1:0] wdata,
   input  logic                             rbank,
   input  entry_t                           rentry,
   input  logic [PW-1:0]                    rplane,
   output word_t                            rword
);
   logic [NB_DRIVERS*POKER_MODE-1:0] mem [2][NB_CHANNELS];
   logic [NB_DRIVERS*POKER_MODE-1:0] ent;
   always_ff @(posedge clk_33) if (we) mem[wbank][wentry] <= wdata;
   assign ent = mem[rbank][rentry];
   for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_lane
      logic [POKER_MODE-1:0] lane;
      assign lane     = ent[d*POKER_MODE +: POKER_MODE];
      assign rword[d] = lane[rplane];
   end
endmodule

// File: rtl/framebuffer_streamer.sv
// framebuffer_streamer: fetches column slices from frame RAM into a ping-pong buffer and streams poker-mode bit-planes
//   clk_33, nrst (async active-low), enable, position_sync (next fetch is slice 0)
//   ram_addr/ram_rd/ram_data: frame RAM read port, data one cycle after ram_rd
//   framebuffer_dat: 30-bit driver word, framebuffer_sync: pulse on the last blanking cycle
//   FB_TEST_PATTERN_EN: adds test_pattern input; a fetch started with it high writes entry c as value c
module framebuffer_streamer
   import streamer_pkg::*;
#(
   parameter int  POKER_MODE      = 9,
   parameter int  BLANKING_CYCLES = 72,
   parameter int  NB_SLICES       = 128,
   localparam int AW = $clog2(NB_SLICES*NB_CHANNELS),
   localparam int SW = NB_SLICES > 1 ? $clog2(NB_SLICES) : 1,
   localparam int PW = POKER_MODE > 1 ? $clog2(POKER_MODE) : 1,
   localparam int CW = $clog2(BLANKING_CYCLES + 1)
) (
   input  logic                             clk_33,
   input  logic                             nrst,
   input  logic                             enable,
   input  logic                             position_sync,
`ifdef FB_TEST_PATTERN_EN
   input  logic                             test_pattern,
`endif
   output logic [AW-1:0]                    ram_addr,
   output logic                             ram_rd,
   input  logic [NB_DRIVERS*POKER_MODE-1:0] ram_data,
   output word_t                            framebuffer_dat,
   output logic                             framebuffer_sync
);
   localparam entry_t        LAST_CH = entry_t'(NB_CHANNELS-1);
   localparam logic [PW-1:0] LAST_PL = PW'(POKER_MODE-1);
   state_t        state;
   logic [CW-1:0] cnt;
   entry_t        ch, fidx, cap_idx, rd_ch;
   logic [PW-1:0] pl, rd_pl;
   logic [SW-1:0] slice, next_slice;
   logic          act, fbank, fetching, cap_v, pend, tp, tp_q, start;
   word_t         rword;
`ifdef FB_TEST_PATTERN_EN
   assign tp = test_pattern;
`else
   assign tp = 1'b0;
`endif
   // read pointer looks one word ahead so the registered output shows the current word
   always_comb begin
      start      = state == S_IDLE || (state == S_BLANK && cnt == CW'(BLANKING_CYCLES-1));
      next_slice = (state == S_IDLE || pend || position_sync || slice == SW'(NB_SLICES-1)) ? '0 : slice + 1'b1;
      rd_ch      = (state == S_STREAM && ch != '0) ? ch - 1'b1 : LAST_CH;
      rd_pl      = state != S_STREAM ? LAST_PL : ch == '0 ? pl - 1'b1 : pl;
   end
   bitplane_buffer #(.POKER_MODE(POKER_MODE)) u_buf (
      .clk_33 (clk_33),
      .we     (cap_v),
      .wbank  (fbank),
      .wentry (cap_idx),
      .wdata  (tp_q ? {NB_DRIVERS{POKER_MODE'(cap_idx)}} : ram_data),
      .rbank  (act),
      .rentry (rd_ch),
      .rplane (rd_pl),
      .rword  (rword)
   );
   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE; cnt <= '0; ch <= '0; pl <= '0; slice <= '0;
         act <= 1'b0; fbank <= 1'b0; fetching <= 1'b0; cap_v <= 1'b0; pend <= 1'b0; tp_q <= 1'b0;
         fidx <= '0; cap_idx <= '0; ram_addr <= '0; ram_rd <= 1'b0;
         framebuffer_dat <= '0; framebuffer_sync <= 1'b0;
      end else if (!enable) begin
         state <= S_IDLE; cnt <= '0; ch <= '0; pl <= '0; slice <= '0;
         act <= 1'b0; fbank <= 1'b0; fetching <= 1'b0; cap_v <= 1'b0; pend <= 1'b0; tp_q <= 1'b0;
         fidx <= '0; cap_idx <= '0; ram_addr <= '0; ram_rd <= 1'b0;
         framebuffer_dat <= '0; framebuffer_sync <= 1'b0;
      end else begin
         cap_v   <= fetching;
         cap_idx <= fidx;
         if (start) begin
            fetching <= 1'b1;
            ram_rd   <= !tp;
            tp_q     <= tp;
            fidx     <= '0;
            ram_addr <= AW'(next_slice * NB_CHANNELS);
            slice    <= next_slice;
            fbank    <= state == S_IDLE ? 1'b0 : !act;
            pend     <= 1'b0;
         end else begin
            if (fetching) begin
               fetching <= fidx != LAST_CH;
               ram_rd   <= fidx != LAST_CH && !tp_q;
               fidx     <= fidx + 1'b1;
               ram_addr <= ram_addr + 1'b1;
            end
            // the priming fetch is always slice 0, so a reference pulse during it is dropped
            pend <= state != S_PRIME && (pend || position_sync);
         end
         if (state == S_IDLE) begin
            state <= S_PRIME;
         end else if (state == S_PRIME && cap_v && cap_idx == LAST_CH) begin
            state            <= S_BLANK;
            cnt              <= '0;
            framebuffer_sync <= BLANKING_CYCLES == 1;
         end else if (state == S_BLANK) begin
            cnt              <= cnt + 1'b1;
            framebuffer_sync <= cnt == CW'(BLANKING_CYCLES-2);
            if (start) begin
               state            <= S_STREAM;
               framebuffer_sync <= 1'b0;
               framebuffer_dat  <= rword;
               ch               <= LAST_CH;
               pl               <= LAST_PL;
            end
         end else if (state == S_STREAM) begin
            if (ch == '0 && pl == '0) begin
               state            <= S_BLANK;
               cnt              <= '0;
               act              <= !act;
               framebuffer_dat  <= '0;
               framebuffer_sync <= BLANKING_CYCLES == 1;
            end else begin
               framebuffer_dat <= rword;
               ch              <= rd_ch;
               pl              <= rd_pl;
            end
         end
      end
   end
endmodule
